iahb_master: RTL and testbench

- AHB-Lite instruction-fetch master. It sits directly downstream of the instruction memory controller's IAHB request port.
- Converts a held IAHB_access/IAHB_addr request into a single-word AHB-Lite read.
- Returns a one-cycle IAHB_read_data_valid pulse with the fetched word to the controller.
- Handles wait states, ERROR responses and pipeline flush (PC redirect) without ever violating AHB-Lite master rules.

---
 rtl/iahb_master_if.sv | 26 ++
 rtl/iahb_master.sv | 112 +++++++++++
 tb/tb_iahb_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/iahb_master_if.sv
// rtl/iahb_master_if.sv - AHB-Lite bus bundle between the instruction-fetch master and the slave side
interface iahb_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRDATA, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRDATA, HRESP
    );
endinterface

// File: rtl/iahb_master.sv
// rtl/iahb_master.sv - AHB-Lite single-word instruction-fetch master with wait-state, ERROR and flush handling
module iahb_master #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VAL  = 4'b0010
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  IAHB_access,
    input  logic [ADDR_WIDTH-1:0] IAHB_addr,
    input  logic                  instr_flush,
    output logic [DATA_WIDTH-1:0] IAHB_read_data,
    output logic                  IAHB_read_data_valid,
    output logic                  IAHB_bus_err,
    output logic [ADDR_WIDTH-1:0] IAHB_err_addr,
    iahb_master_if.master         ahb
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  valid_q, valid_d;
    logic                  berr_q, berr_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                  kill_q, kill_d;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_q    <= S_IDLE;
            haddr_q    <= '0;
            htrans_q   <= TRANS_IDLE;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            berr_q     <= 1'b0;
            err_addr_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            htrans_q   <= htrans_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            berr_q     <= berr_d;
            err_addr_q <= err_addr_d;
            kill_q     <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        htrans_d   = htrans_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        berr_d     = 1'b0;
        err_addr_d = err_addr_q;
        kill_d     = kill_q;
        unique case (state_q)
            S_IDLE: begin
                htrans_d = TRANS_IDLE;
                if (IAHB_access && !instr_flush) begin
                    haddr_d  = IAHB_addr & ~(ADDR_WIDTH'(3));
                    htrans_d = TRANS_NONSEQ;
                    state_d  = S_ADDR;
                end
            end
            // NONSEQ is never withdrawn once driven; a flush only marks the result as dead
            S_ADDR: begin
                if (instr_flush) kill_d = 1'b1;
                if (ahb.HREADY) begin
                    htrans_d = TRANS_IDLE;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (instr_flush) kill_d = 1'b1;
                if (ahb.HREADY) begin
                    if (!kill_q && !instr_flush) begin
                        rdata_d = ahb.HRDATA;
                        valid_d = 1'b1;
                        berr_d  = ahb.HRESP;
                    end
                    if (ahb.HRESP) err_addr_d = haddr_q;
                    state_d = S_RESP;
                end
            end
            // Request is deliberately ignored here so a still-held request is not re-issued
            S_RESP: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign IAHB_read_data       = rdata_q;
    assign IAHB_read_data_valid = valid_q;
    assign IAHB_bus_err         = berr_q;
    assign IAHB_err_addr        = err_addr_q;

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = 1'b0;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = HPROT_VAL;
    assign ahb.HWDATA = '0;
endmodule

// File: tb/tb_iahb_master.sv
// tb/tb_iahb_master.sv - bench for iahb_master driving scripted wait states against a cycle-count reference model
module tb_iahb_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        access;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] rdata;
    logic        valid;
    logic        berr;
    logic [31:0] err_addr;

    int n_assert = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int exp_xfers = 0;
    logic [31:0] model_err_addr = 32'h0;

    iahb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    iahb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_VAL(4'b0010)) dut (
        .cpu_clk              (clk),
        .cpu_rstn             (rst_n),
        .IAHB_access          (access),
        .IAHB_addr            (addr),
        .instr_flush          (flush),
        .IAHB_read_data       (rdata),
        .IAHB_read_data_valid (valid),
        .IAHB_bus_err         (berr),
        .IAHB_err_addr        (err_addr),
        .ahb                  (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && bus.HTRANS == 2'b10 && bus.HREADY) xfers++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. Cycle 0 presents the request; cycle k is checked at its negedge.
    // aw/dw: HREADY-low cycles in address/data phase; flush_k: cycle carrying a flush pulse (-1 none).
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int aw, input int dw,
                         input bit err, input int flush_k, input bit hold, input string tag);
        int vk;
        bit in_addr;
        bit exp_v;
        logic [31:0] ea;
        vk = aw + dw + 3;
        ea = a & 32'hFFFF_FFFC;
        access = 1'b1; addr = a; flush = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
        for (int k = 1; k <= vk + 1; k++) begin
            @(negedge clk);
            in_addr = (k <= aw + 1);
            exp_v   = (k == vk) && (flush_k < 0);
            chk({tag, " htrans"}, {30'd0, bus.HTRANS}, in_addr ? 32'd2 : 32'd0);
            if (in_addr) chk({tag, " haddr"}, bus.HADDR, ea);
            chk({tag, " valid"}, {31'd0, valid}, {31'd0, exp_v});
            chk({tag, " bus_err"}, {31'd0, berr}, {31'd0, exp_v & err});
            if (exp_v) chk({tag, " rdata"}, rdata, d);
            flush = (k == flush_k);
            if (k == flush_k) access = 1'b0;
            if (k == vk && !hold) access = 1'b0;
            if (k == vk + 1) access = 1'b0;
            if (k <= aw) begin
                bus.HREADY = 1'b0; bus.HRESP = 1'b0;
            end else if (k == aw + 1) begin
                bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            end else if (k < aw + dw + 2) begin
                bus.HREADY = 1'b0; bus.HRESP = err && (k == aw + dw + 1); bus.HRDATA = $urandom;
            end else if (k == aw + dw + 2) begin
                bus.HREADY = 1'b1; bus.HRESP = err; bus.HRDATA = d;
            end else begin
                bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = $urandom;
            end
        end
        if (err) model_err_addr = ea;
        exp_xfers++;
        chk({tag, " err_addr"}, err_addr, model_err_addr);
        chk({tag, " xfer count"}, xfers, exp_xfers);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " htrans"}, {30'd0, bus.HTRANS}, 32'd0);
        chk({tag, " haddr"}, bus.HADDR, 32'd0);
        chk({tag, " rdata"}, rdata, 32'd0);
        chk({tag, " valid"}, {31'd0, valid}, 32'd0);
        chk({tag, " bus_err"}, {31'd0, berr}, 32'd0);
        chk({tag, " err_addr"}, err_addr, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rd;
        int aw, dw;
        bit er;
        rst_n = 1'b0; access = 1'b0; addr = 32'h0; flush = 1'b0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        chk("hwrite", {31'd0, bus.HWRITE}, 32'd0);
        chk("hsize", {29'd0, bus.HSIZE}, 32'd2);
        chk("hburst", {29'd0, bus.HBURST}, 32'd0);
        chk("hprot", {28'd0, bus.HPROT}, 32'd2);
        chk("hwdata", bus.HWDATA, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        fetch(32'h0000_2004, 32'h0010_0093, 0, 0, 1'b0, -1, 1'b0, "t1");
        fetch(32'h0000_2008, $urandom, 3, 2, 1'b0, -1, 1'b0, "t2 waits");
        fetch(32'h0000_3000, $urandom, 0, 1, 1'b1, -1, 1'b0, "t3 error");
        fetch(32'h0000_300C, $urandom, 1, 0, 1'b0, -1, 1'b0, "t3 after");

        access = 1'b1; addr = 32'h0000_3800; flush = 1'b1;
        @(negedge clk);
        chk("idle flush blocks", {30'd0, bus.HTRANS}, 32'd0);
        access = 1'b0; flush = 1'b0;
        @(negedge clk);

        fetch(32'h0000_4444, $urandom, 2, 1, 1'b0, 1, 1'b0, "t4 flush addr");
        fetch(32'h0000_4000, $urandom, 0, 0, 1'b0, -1, 1'b0, "t4 after");
        fetch(32'h0000_4800, $urandom, 0, 2, 1'b0, 3, 1'b0, "flush data");
        fetch(32'h0000_5000, $urandom, 0, 0, 1'b0, -1, 1'b1, "t5 hold");
        fetch(32'h0000_5100, $urandom, 1, 1, 1'b0, -1, 1'b0, "t5 next");

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rd = $urandom;
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            er = (dw > 0) && ($urandom_range(0, 2) == 0);
            fetch(ra, rd, aw, dw, er, -1, 1'b0, "rand");
        end

        access = 1'b1; addr = $urandom; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.HREADY = 1'b0;
        chk("t6 in data", {30'd0, bus.HTRANS}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t6 async");
        access = 1'b0; bus.HREADY = 1'b1; bus.HRDATA = $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t6 no valid", {31'd0, valid}, 32'd0);
            chk("t6 idle", {30'd0, bus.HTRANS}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
